// File: rtl/pushbtn_pkg.sv
// Shared definitions for the KEY push-button controller: register word
// addresses, bus width and the debounce counter sizing helper.
package pushbtn_pkg;

    typedef enum logic [1:0] {
        ADDR_STATE   = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_RSVD    = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int unsigned BUS_W = 32;

    // Wide enough to hold the full debounce count without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pushbtn_event_ctrl_if.sv
// Avalon-MM register port of the push-button controller, with master
// (bridge side) and slave (controller side) views.
interface pushbtn_event_ctrl_if;
    import pushbtn_pkg::*;

    logic [1:0]       address;
    logic             read;
    logic             write;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (output address, output read, output write, output writedata, input readdata);
    modport slave  (input address, input read, input write, input writedata, output readdata);

endinterface

// File: rtl/pushbtn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level (pressed=1) and one-cycle press/release pulses.
module pushbtn_debounce
    import pushbtn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);
    localparam int            CW           = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic          RELEASED_PIN = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Synchroniser resets to the released pin level so reset exit produces no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RELEASED_PIN;
            sync2_q <= RELEASED_PIN;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    // Debounce counter, accepted level and edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= {CW{1'b0}};
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any sample matching the accepted level restarts the count.
    always_comb begin
        cnt_d   = {CW{1'b0}};
        state_d = state_q;
        if (pressed_s != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = pressed_s;
                cnt_d   = {CW{1'b0}};
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
        press_d   = state_d & ~state_q;
        release_d = state_q & ~state_d;
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/pushbtn_event_ctrl.sv
// Avalon-MM push-button controller: per-key debounce, sticky W1C edge capture,
// mask register and level irq. PUSHBTN_RELEASE_EDGE_EN adds release-edge capture.
module pushbtn_event_ctrl
    import pushbtn_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pushbtn_event_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
`ifdef PUSHBTN_RELEASE_EDGE_EN
    localparam int EW = 2 * WIDTH;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] state_s, press_s, release_s;
    logic [EW-1:0]    set_s, clr_s;
    logic [EW-1:0]    irqmask_q, irqmask_d;
    logic [EW-1:0]    edgecap_q, edgecap_d;
    logic [BUS_W-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        pushbtn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk       (clk),
            .reset_n   (reset_n),
            .pin_i     (in_port[g]),
            .state_o   (state_s[g]),
            .press_o   (press_s[g]),
            .release_o (release_s[g])
        );
    end

    // Reads have no side effects, so the strobe is not needed.
`ifdef PUSHBTN_RELEASE_EDGE_EN
    assign set_s    = {release_s, press_s};
    assign unused_s = ^{bus.read, bus.writedata[BUS_W-1:EW]};
`else
    assign set_s    = press_s;
    assign unused_s = ^{bus.read, bus.writedata[BUS_W-1:EW], release_s};
`endif

    // Register bank, read data pipeline and interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= {EW{1'b0}};
            edgecap_q  <= {EW{1'b0}};
            readdata_q <= {BUS_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    // Write decode, set-wins capture update and read mux.
    always_comb begin
        clr_s     = {EW{1'b0}};
        irqmask_d = irqmask_q;
        if (bus.write) begin
            case (reg_addr_e'(bus.address))
                ADDR_IRQMASK: irqmask_d = bus.writedata[EW-1:0];
                ADDR_EDGECAP: clr_s     = bus.writedata[EW-1:0];
                default: begin
                    clr_s     = {EW{1'b0}};
                    irqmask_d = irqmask_q;
                end
            endcase
        end else begin
            clr_s     = {EW{1'b0}};
            irqmask_d = irqmask_q;
        end

        edgecap_d = (edgecap_q & ~clr_s) | set_s;
        irq_d     = |(edgecap_q & irqmask_q);

        case (reg_addr_e'(bus.address))
            ADDR_STATE:   readdata_d = BUS_W'(state_s);
            ADDR_IRQMASK: readdata_d = BUS_W'(irqmask_q);
            ADDR_EDGECAP: readdata_d = BUS_W'(edgecap_q);
            default:      readdata_d = {BUS_W{1'b0}};
        endcase
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pushbtn_event_ctrl.sv
// Scoreboard bench for pushbtn_event_ctrl (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1);
// expectations adapt when PUSHBTN_RELEASE_EDGE_EN is defined.
module tb_pushbtn_event_ctrl;

`ifdef PUSHBTN_RELEASE_EDGE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_irq;
        logic        exp_irq;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;

    exp_t sb_q[$];
    exp_t mon_e;
    logic probe      = 1'b0;
    logic pend       = 1'b0;
    logic drain_req  = 1'b0;
    logic drain_done = 1'b0;
    int   checks     = 0;
    int   failures   = 0;

    pushbtn_event_ctrl_if bus ();

    pushbtn_event_ctrl #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A probe issued in one cycle is resolved after the following rising edge.
    always @(posedge clk) pend <= probe;

    always @(negedge clk) begin
        if (pend) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: DUT response with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_rd) begin
                    checks++;
                    if (bus.readdata !== mon_e.exp_rd) begin
                        failures++;
                        $display("FAIL %s readdata actual=%h required=%h", mon_e.name, bus.readdata, mon_e.exp_rd);
                    end
                end
                if (mon_e.chk_irq) begin
                    checks++;
                    if (irq !== mon_e.exp_irq) begin
                        failures++;
                        $display("FAIL %s irq actual=%b required=%b", mon_e.name, irq, mon_e.exp_irq);
                    end
                end
            end
        end
        if (drain_req && !drain_done) begin
            checks++;
            if (sb_q.size() != 0) begin
                failures++;
                $display("FAIL sb_drain: pending=%0d required=0", sb_q.size());
            end
            drain_done = 1'b1;
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d,
                       input bit crd, input logic [31:0] erd, input bit cirq, input logic eirq,
                       input string nm);
        exp_t e;
        bus.address   = a;
        bus.write     = w;
        bus.read      = r;
        bus.writedata = d;
        if (crd || cirq) begin
            e.name    = nm;
            e.chk_rd  = crd;
            e.exp_rd  = erd;
            e.chk_irq = cirq;
            e.exp_irq = eirq;
            sb_q.push_back(e);
            probe = 1'b1;
        end
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        probe     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0, 32'd0, 1'b0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        cyc(1'b0, 1'b1, a, 32'd0, 1'b1, e, 1'b0, 1'b0, nm);
    endtask

    task automatic irq_chk(input logic e, input string nm);
        cyc(1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 32'd0, 1'b1, e, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        in_port       = 4'hF;
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        idle(3);
        reset_n = 1'b1;
        idle(8);

        // Reset state, no spurious edge on reset exit.
        rd(2'd0, 32'h0, "rst_state");
        rd(2'd3, 32'h0, "rst_edgecap");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_rsvd");
        irq_chk(1'b0, "rst_irq");

        // Key0 press: STATE visible on the read issued 6 cycles after the pin change.
        in_port[0] = 1'b0;
        for (int i = 0; i < 7; i++) rd(2'd0, (i == 6) ? 32'h1 : 32'h0, $sformatf("lat_state_%0d", i));
        rd(2'd3, 32'h1, "press_edgecap");
        irq_chk(1'b0, "irq_masked");
        cyc(1'b1, 1'b0, 2'd1, 32'h1, 1'b0, 32'd0, 1'b1, 1'b0, "irq_before_mask");
        irq_chk(1'b1, "irq_after_mask");

        in_port[0] = 1'b1;
        idle(8);
        wr(2'd3, 32'hFF);
        idle(1);
        rd(2'd3, 32'h0, "clr_all");
        irq_chk(1'b0, "irq_cleared");

        // Bouncing key1 never stays stable long enough.
        for (int i = 0; i < 10; i++) begin
            in_port[1] = ~in_port[1];
            idle(2);
        end
        in_port[1] = 1'b1;
        idle(8);
        rd(2'd0, 32'h0, "bounce_state");
        rd(2'd3, 32'h0, "bounce_edgecap");

        // W1C of one bit, then clear colliding with a new capture.
        in_port = 4'hC;
        idle(10);
        in_port = 4'hF;
        idle(10);
        rd(2'd3, REL ? 32'h33 : 32'h03, "edgecap_two");
        wr(2'd3, 32'h1);
        rd(2'd3, REL ? 32'h32 : 32'h02, "w1c_bit0");
        in_port[1] = 1'b0;
        idle(6);
        wr(2'd3, 32'h2);
        rd(2'd3, REL ? 32'h32 : 32'h02, "set_wins");
        in_port = 4'hF;
        idle(10);
        wr(2'd3, 32'hFF);
        idle(1);
        rd(2'd3, 32'h0, "clr_after_collide");

        // Reset in the middle of a debounce with the key still held.
        in_port[0] = 1'b0;
        idle(4);
        reset_n = 1'b0;
        rd(2'd1, 32'h0, "midrst_mask");
        rd(2'd3, 32'h0, "midrst_edgecap");
        rd(2'd0, 32'h0, "midrst_state");
        irq_chk(1'b0, "midrst_irq");
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) rd(2'd0, (i == 6) ? 32'h1 : 32'h0, $sformatf("rerun_state_%0d", i));
        rd(2'd3, 32'h1, "rerun_edgecap");

        // Ignored writes, widened capture of key2 and mask read-back width.
        in_port = 4'hF;
        idle(10);
        wr(2'd3, 32'hFF);
        rd(2'd3, 32'h0, "clr_before_key2");
        wr(2'd0, 32'hFF);
        rd(2'd0, 32'h0, "state_wr_ignored");
        wr(2'd2, 32'hFF);
        rd(2'd2, 32'h0, "rsvd_wr_ignored");
        in_port[2] = 1'b0;
        idle(10);
        in_port = 4'hF;
        idle(10);
        rd(2'd3, REL ? 32'h44 : 32'h04, "key2_edgecap");
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1, REL ? 32'hFF : 32'h0F, "mask_width");
        irq_chk(1'b1, "irq_key2");

        idle(2);
        drain_req = 1'b1;
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
